lcd_timing_sequencer: RTL and testbench
=======================================

// Module: lcd_timing_sequencer
// PURPOSE
//  Dot/line timing controller that drives the video renderer and the CPU-side video
//  register block. Counts dots per line and lines per frame, and derives LCD mode
//  (OAM scan / transfer / HBLANK / VBLANK) from those counters. Emits the per-line
//  draw strobe and the frame-complete flag, and raises the VBLANK and STAT interrupt
//  pulses. Also drives the OAM and VRAM CPU-access lock signals.
// PARAMETERS
//  DOTS_PER_LINE   456  dots per line, including HBLANK
//  VISIBLE_LINES   144  rendered lines per frame
//  TOTAL_LINES     154  visible lines plus VBLANK lines
//  OAM_SCAN_DOTS    80  mode-2 length at the start of each visible line
//  XFER_DOTS       172  mode-3 length; OAM_SCAN_DOTS+XFER_DOTS < DOTS_PER_LINE required
// PORTS
//  clk            in   1  system clock
//  reset_n        in   1  asynchronous reset, active low
//  lcd_enable     in   1  LCDC display-enable bit
//  lyc            in   8  line-compare value (LYC register)
//  stat_int_en    in   4  [0]=HBLANK [1]=VBLANK [2]=OAM [3]=LYC STAT sources
//  ly             out  8  current line 0..TOTAL_LINES-1
//  dot            out  9  current dot 0..DOTS_PER_LINE-1
//  mode           out  2  0=HBLANK 1=VBLANK 2=OAM scan 3=transfer
//  lyc_match      out  1  ly == lyc while enabled
//  drawline       out  1  1-cycle strobe: render line `ly` now
//  render_complete out 1  high throughout VBLANK
//  vblank_irq     out  1  1-cycle pulse on VBLANK entry
//  stat_irq       out  1  1-cycle pulse on rising edge of STAT line
//  oam_lock       out  1  CPU OAM access blocked (mode 2 or 3)
//  vram_lock      out  1  CPU VRAM access blocked (mode 3)
// BEHAVIOUR
//  - State regs: dot, ly, stat_line_q. Reset (async, reset_n=0): all 0; all outputs 0,
//    except mode, which is 0.
//  - lcd_enable=0: next edge forces dot=0, ly=0, stat_line_q=0; all outputs are gated
//    combinationally to 0 in the same cycle (mode=0, no locks, no pulses).
//  - lcd_enable=1, per edge: dot++. At dot=DOTS_PER_LINE-1, dot->0 and ly++. At
//    ly=TOTAL_LINES-1 with dot wrap, ly->0. No other wrap values exist.
//  - First enabled cycle after being off: dot=0, ly=0, mode=2.
//  - mode (combinational from regs):
//      ly>=VISIBLE_LINES                  -> 1
//      else dot<OAM_SCAN_DOTS             -> 2
//      else dot<OAM_SCAN_DOTS+XFER_DOTS   -> 3
//      else                               -> 0
//  - drawline = en & ly<VISIBLE_LINES & dot==OAM_SCAN_DOTS. Exactly one pulse per visible
//    line, none during VBLANK.
//  - render_complete = en & (mode==1). vblank_irq = en & ly==VISIBLE_LINES & dot==0.
//  - lyc_match = en & (ly==lyc). A change of lyc takes effect the same cycle.
//  - stat_line = |(stat_int_en & {lyc_match, mode==2, mode==1, mode==0}).
//    stat_irq = stat_line & ~stat_line_q; stat_line_q <= stat_line.
//    If sources overlap so stat_line stays high (e.g. HBLANK->OAM), no new pulse is made.
//  - oam_lock = en & mode[1]; vram_lock = en & (mode==3).
//  - Reset asserted mid-frame aborts immediately: outputs 0 asynchronously, counters
//    restart at 0.
//  - Interrupt pulses go to the interrupt controller, which latches them. This block
//    holds no pending state.
// TESTING
//  1. Hold reset_n=0 with lcd_enable=1 -> ly=0, dot=0, mode=0, all pulses and locks 0;
//     release -> first edge gives dot=1, mode=2.
//  2. Enable at cycle 0 -> drawline only at cycle 80; mode=3 for cycles 80..251,
//     mode=0 for 252..455; ly=1 at cycle 456; vram_lock high exactly 172 cycles.
//  3. Free-run one frame -> vblank_irq single pulse at cycle 65664 (ly=144), mode=1 and
//     render_complete high until cycle 70224, where ly=0 and mode=2; 144 drawline pulses
//     per frame.
//  4. lyc=5, stat_int_en=4'b1000 -> one stat_irq pulse at cycle 2280 (ly=5, dot=0),
//     none elsewhere in the frame; lyc=200 -> no pulse ever.
//  5. stat_int_en=4'b0101 (HBLANK+OAM) -> stat_irq pulses at the line-0 start and at
//     dot 252 of line 0; no pulse at line-1 start (line stays high).
//  6. Drop lcd_enable at ly=50, dot=100 -> same cycle: locks, mode, and all pulses go to 0;
//     next edge: ly=0, dot=0. Re-enable -> normal timing from line 0.

Source files
------------

// File: rtl/lcd_timing_sequencer.sv
// LCD dot/line timing sequencer: dot and line counters, mode decode, render
// strobes, VBLANK/STAT interrupt pulses and CPU access locks for OAM/VRAM.
module lcd_timing_sequencer #(
    parameter int unsigned DOTS_PER_LINE = 456,
    parameter int unsigned VISIBLE_LINES = 144,
    parameter int unsigned TOTAL_LINES   = 154,
    parameter int unsigned OAM_SCAN_DOTS = 80,
    parameter int unsigned XFER_DOTS     = 172
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic [1:0] mode,
    output logic       lyc_match,
    output logic       drawline,
    output logic       render_complete,
    output logic       vblank_irq,
    output logic       stat_irq,
    output logic       oam_lock,
    output logic       vram_lock
);

    localparam int unsigned DOT_W  = 9;
    localparam int unsigned LY_W   = 8;
    localparam int unsigned STAT_W = 4;

    localparam logic [DOT_W-1:0] DOT_LAST         = DOT_W'(DOTS_PER_LINE - 1);
    localparam logic [DOT_W-1:0] DOT_XFER_START   = DOT_W'(OAM_SCAN_DOTS);
    localparam logic [DOT_W-1:0] DOT_HBLANK_START = DOT_W'(OAM_SCAN_DOTS + XFER_DOTS);
    localparam logic [LY_W-1:0]  LY_LAST          = LY_W'(TOTAL_LINES - 1);
    localparam logic [LY_W-1:0]  LY_VBLANK_START  = LY_W'(VISIBLE_LINES);

    typedef enum logic [1:0] {
        MODE_HBLANK = 2'd0,
        MODE_VBLANK = 2'd1,
        MODE_OAM    = 2'd2,
        MODE_XFER   = 2'd3
    } lcd_mode_e;

    logic [DOT_W-1:0]  dot_q, dot_d;
    logic [LY_W-1:0]   ly_q, ly_d;
    logic              stat_line_q, stat_line_d;

    logic              en_c;
    logic              visible_c;
    lcd_mode_e         mode_raw_c;
    lcd_mode_e         mode_c;
    logic              lyc_match_c;
    logic [STAT_W-1:0] stat_src_c;
    logic              stat_line_c;

    // Reset gates outputs asynchronously, so it participates in the enable.
    assign en_c      = lcd_enable & reset_n;
    assign visible_c = (ly_q < LY_VBLANK_START);

    // Raw mode decode from the counters, before display-enable gating.
    always_comb begin
        mode_raw_c = MODE_HBLANK;
        if (!visible_c) begin
            mode_raw_c = MODE_VBLANK;
        end else if (dot_q < DOT_XFER_START) begin
            mode_raw_c = MODE_OAM;
        end else if (dot_q < DOT_HBLANK_START) begin
            mode_raw_c = MODE_XFER;
        end
    end

    assign mode_c      = en_c ? mode_raw_c : MODE_HBLANK;
    assign lyc_match_c = en_c & (ly_q == lyc);

    // STAT sources ordered {LYC, OAM, VBLANK, HBLANK} to line up with the enable mask.
    assign stat_src_c  = {lyc_match_c,
                          (mode_c == MODE_OAM),
                          (mode_c == MODE_VBLANK),
                          (mode_c == MODE_HBLANK)};
    assign stat_line_c = en_c & (|(stat_int_en & stat_src_c));

    // Next-state: counters advance while enabled, collapse to zero while disabled.
    always_comb begin
        dot_d       = dot_q;
        ly_d        = ly_q;
        stat_line_d = stat_line_q;
        if (!lcd_enable) begin
            dot_d       = '0;
            ly_d        = '0;
            stat_line_d = 1'b0;
        end else begin
            stat_line_d = stat_line_c;
            if (dot_q == DOT_LAST) begin
                dot_d = '0;
                if (ly_q == LY_LAST) begin
                    ly_d = '0;
                end else begin
                    ly_d = ly_q + LY_W'(1);
                end
            end else begin
                dot_d = dot_q + DOT_W'(1);
            end
        end
    end

    // Timing state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q       <= '0;
            ly_q        <= '0;
            stat_line_q <= 1'b0;
        end else begin
            dot_q       <= dot_d;
            ly_q        <= ly_d;
            stat_line_q <= stat_line_d;
        end
    end

    assign ly              = ly_q;
    assign dot             = dot_q;
    assign mode            = mode_c;
    assign lyc_match       = lyc_match_c;
    assign drawline        = en_c & visible_c & (dot_q == DOT_XFER_START);
    assign render_complete = en_c & (mode_c == MODE_VBLANK);
    assign vblank_irq      = en_c & (ly_q == LY_VBLANK_START) & (dot_q == '0);
    // Rising edge only: overlapping sources that keep the line high make no new pulse.
    assign stat_irq        = stat_line_c & ~stat_line_q;
    assign oam_lock        = en_c & mode_c[1];
    assign vram_lock       = en_c & (mode_c == MODE_XFER);

endmodule

// File: tb/tb_lcd_timing_sequencer.sv
// Scoreboard bench for lcd_timing_sequencer: the driver queues expected state
// snapshots and pulse events by absolute cycle; the monitor checks them at negedge.
module tb_lcd_timing_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       lcd_enable;
    logic [7:0] lyc;
    logic [3:0] stat_int_en;
    logic [7:0] ly;
    logic [8:0] dot;
    logic [1:0] mode;
    logic       lyc_match, drawline, render_complete, vblank_irq, stat_irq, oam_lock, vram_lock;

    lcd_timing_sequencer dut (
        .clk(clk), .reset_n(reset_n), .lcd_enable(lcd_enable), .lyc(lyc),
        .stat_int_en(stat_int_en), .ly(ly), .dot(dot), .mode(mode),
        .lyc_match(lyc_match), .drawline(drawline), .render_complete(render_complete),
        .vblank_irq(vblank_irq), .stat_irq(stat_irq), .oam_lock(oam_lock),
        .vram_lock(vram_lock)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int          cyc;
        int          id;
        logic [22:0] exp;
    } snap_t;

    typedef struct packed {
        int cyc;
        int kind;   // 0=drawline 1=vblank_irq 2=stat_irq
    } pulse_t;

    snap_t  sq[$];
    pulse_t pq[$];

    int tb_cyc  = 0;
    int n_tests = 0;
    int n_fail  = 0;
    int snap_id = 0;
    bit done    = 1'b0;

    logic [22:0] act;
    assign act = {ly, dot, mode, oam_lock, vram_lock, render_complete, lyc_match};

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    function automatic string kname(input int k);
        if (k == 0) return "drawline";
        if (k == 1) return "vblank_irq";
        return "stat_irq";
    endfunction

    task automatic push_snap(input int c, input int l, input int d, input int m,
                             input bit o, input bit v, input bit r, input bit y);
        snap_t s;
        s.cyc = c;
        s.id  = snap_id;
        s.exp = {8'(l), 9'(d), 2'(m), o, v, r, y};
        snap_id++;
        sq.push_back(s);
    endtask

    task automatic push_pulse(input int c, input int k);
        pulse_t p;
        p.cyc  = c;
        p.kind = k;
        pq.push_back(p);
    endtask

    task automatic goto(input int c);
        while (tb_cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare snapshots due this cycle, match every pulse against the queue.
    always @(negedge clk) begin
        logic [2:0]  seen;
        logic [22:0] e;
        if (done) begin
            n_tests++;
            if (sq.size() != 0) begin
                n_fail++;
                $display("FAIL snap_leftover: %0d snapshots pending, required 0", sq.size());
            end
            n_tests++;
            if (pq.size() != 0) begin
                n_fail++;
                $display("FAIL pulse_leftover: %0d pulses pending, required 0", pq.size());
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end else begin
            while (sq.size() > 0 && sq[0].cyc <= tb_cyc) begin
                n_tests++;
                e = sq[0].exp;
                if (sq[0].cyc < tb_cyc) begin
                    n_fail++;
                    $display("FAIL snap%0d stale: checked at cyc %0d, required cyc %0d",
                             sq[0].id, tb_cyc, sq[0].cyc);
                end else if (act !== e) begin
                    n_fail++;
                    $display("FAIL snap%0d cyc %0d: got ly=%0d dot=%0d mode=%0d oam=%b vram=%b rc=%b lm=%b, required ly=%0d dot=%0d mode=%0d oam=%b vram=%b rc=%b lm=%b",
                             sq[0].id, tb_cyc, ly, dot, mode, oam_lock, vram_lock,
                             render_complete, lyc_match, e[22:15], e[14:6], e[5:4],
                             e[3], e[2], e[1], e[0]);
                end
                void'(sq.pop_front());
            end
            seen = {stat_irq, vblank_irq, drawline};
            for (int k = 0; k < 3; k++) begin
                if (seen[k] !== 1'b0) begin
                    n_tests++;
                    if (pq.size() > 0 && pq[0].cyc == tb_cyc && pq[0].kind == k) begin
                        void'(pq.pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL %s cyc %0d: got pulse=%b, required 0",
                                 kname(k), tb_cyc, seen[k]);
                    end
                end
            end
            while (pq.size() > 0 && pq[0].cyc <= tb_cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s cyc %0d: got 0, required pulse at cyc %0d",
                         kname(pq[0].kind), tb_cyc, pq[0].cyc);
                void'(pq.pop_front());
            end
        end
    end

    // Driver: queue expectations, then step inputs at absolute cycles.
    initial begin
        int a;
        int b;
        reset_n     = 1'b0;
        lcd_enable  = 1'b1;
        lyc         = 8'd0;
        stat_int_en = 4'b0101;
        goto(3);

        // Held in reset with display enabled: everything zero, no match on lyc=0.
        push_snap(3, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        a = tb_cyc + 2;

        // Line 0/1 timing from reset release, lyc=0 matches line 0.
        push_snap(a + 0,   0, 0,   2, 1'b1, 1'b0, 1'b0, 1'b1);
        push_snap(a + 1,   0, 1,   2, 1'b1, 1'b0, 1'b0, 1'b1);
        push_snap(a + 79,  0, 79,  2, 1'b1, 1'b0, 1'b0, 1'b1);
        push_snap(a + 80,  0, 80,  3, 1'b1, 1'b1, 1'b0, 1'b1);
        push_snap(a + 251, 0, 251, 3, 1'b1, 1'b1, 1'b0, 1'b1);
        push_snap(a + 252, 0, 252, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_snap(a + 455, 0, 455, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_snap(a + 456, 1, 0,   2, 1'b1, 1'b0, 1'b0, 1'b0);
        // lyc changes take effect in the same cycle.
        push_snap(a + 800, 1, 344, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(a + 900, 1, 444, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_snap(a + 905, 1, 449, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Disable at ly=50 dot=100: gated at once, counters clear on the next edge.
        push_snap(a + 22899, 50, 99,  3, 1'b1, 1'b1, 1'b0, 1'b0);
        push_snap(a + 22900, 50, 100, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(a + 22901, 0,  0,   0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(a + 22902, 0,  0,   0, 1'b0, 1'b0, 1'b0, 1'b0);

        // HBLANK+OAM sources: pulse at line-0 start and at each dot 252, none at line-1 start.
        push_pulse(a + 0,   2);
        push_pulse(a + 80,  0);
        push_pulse(a + 252, 2);
        push_pulse(a + 536, 0);
        push_pulse(a + 708, 2);
        push_pulse(a + 900, 2);
        for (int l = 2; l <= 50; l++) push_pulse(a + 456 * l + 80, 0);

        // Full free-running frame after re-enable, lyc=5 with only the LYC source.
        b = a + 22905;
        push_snap(b + 0,     0,   0,   2, 1'b1, 1'b0, 1'b0, 1'b0);
        push_snap(b + 1,     0,   1,   2, 1'b1, 1'b0, 1'b0, 1'b0);
        push_snap(b + 2279,  4,   455, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(b + 2280,  5,   0,   2, 1'b1, 1'b0, 1'b0, 1'b1);
        push_snap(b + 2735,  5,   455, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        push_snap(b + 2736,  6,   0,   2, 1'b1, 1'b0, 1'b0, 1'b0);
        push_snap(b + 65663, 143, 455, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(b + 65664, 144, 0,   1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_snap(b + 65744, 144, 80,  1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_snap(b + 70223, 153, 455, 1, 1'b0, 1'b0, 1'b1, 1'b0);
        push_snap(b + 70224, 0,   0,   2, 1'b1, 1'b0, 1'b0, 1'b0);
        // Asynchronous reset mid-line clears outputs and counters at once.
        push_snap(b + 70225, 0,   0,   0, 1'b0, 1'b0, 1'b0, 1'b0);
        push_snap(b + 70226, 0,   0,   0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int l = 0; l < 144; l++) begin
            if (l == 5) push_pulse(b + 2280, 2);
            push_pulse(b + 456 * l + 80, 0);
        end
        push_pulse(b + 65664, 1);

        goto(a);
        reset_n = 1'b1;
        goto(a + 800);
        stat_int_en = 4'b1000;
        lyc         = 8'd200;
        goto(a + 900);
        lyc = 8'd1;
        goto(a + 905);
        lyc = 8'd200;
        goto(a + 22900);
        lcd_enable = 1'b0;
        lyc        = 8'd50;
        goto(a + 22903);
        lyc = 8'd5;
        goto(b);
        lcd_enable = 1'b1;
        goto(b + 70225);
        reset_n = 1'b0;
        goto(b + 70227);
        done = 1'b1;
    end

    // Safety net in case the driver stalls.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
